mux_stream_rr: RTL and testbench

- Parametrised successor to the team's gate-level 8:1 mux: an N-channel, W-bit streaming multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Two modes: fixed select, where an external select chooses the channel, and round-robin arbitration across all valid channels.
- Sits between multiple producer streams and one consumer. Tags each output word with its source channel.

---
 rtl/mux_stream_pkg.sv | 20 ++
 rtl/rr_pick.sv | 39 +++
 rtl/mux_stream_rr.sv | 105 ++++++++++
 tb/tb_mux_stream_rr.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// ============================================================================
// Module      : mux_stream_pkg
// Description : Shared mode encodings and pointer-wrap helper for mux_stream_rr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wraps explicitly so that non-power-of-2 channel counts never reach an unused index.
  function automatic int next_ptr(input int idx, input int nch);
    return (idx >= nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Rotating priority encoder; first set request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NCH  = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);

  int w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      if (!any_gnt && req[w_idx]) begin
        any_gnt      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = SELW'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_stream_rr.sv
// ============================================================================
// Module      : mux_stream_rr
// Description : N-channel streaming mux, fixed-select or round-robin, registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_stream_rr
  import mux_stream_pkg::*;
#(
  parameter  int NCH  = 8,
  parameter  int W    = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [NCH-1:0]  w_rr_gnt, w_fix_gnt, w_gnt;
  logic [SELW-1:0] w_rr_idx, w_ch;
  logic            w_rr_any, w_any, w_load_en, w_xfer;
  logic [W-1:0]    w_word;

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx),
    .any_gnt (w_rr_any)
  );

  // A select value beyond the last channel matches no bit, so it yields no grant.
  always_comb begin
    w_fix_gnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_fix_gnt[i] = in_valid[i] && (sel == SELW'(i));
    end
  end

  always_comb begin
    w_gnt     = (mode == MODE_RR) ? w_rr_gnt : w_fix_gnt;
    w_any     = (mode == MODE_RR) ? w_rr_any : |w_fix_gnt;
    w_ch      = (mode == MODE_RR) ? w_rr_idx : sel;
    w_load_en = !out_valid_q || out_ready;
    w_xfer    = w_any && w_load_en && !rst;
    in_ready  = (rst || !w_load_en) ? '0 : w_gnt;
    w_word    = '0;
    for (int i = 0; i < NCH; i++) begin
      w_word = w_word | (in_data[i*W +: W] & {W{w_gnt[i]}});
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (w_xfer) begin
      out_data_d  = w_word;
      out_ch_d    = w_ch;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) ptr_d = SELW'(next_ptr(int'(w_ch), NCH));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_stream_rr.sv
// ============================================================================
// Module      : tb_mux_stream_rr
// Description : Directed self-checking bench for mux_stream_rr (NCH=8 and NCH=6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_stream_rr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Eight-channel instance
  logic        rst;
  logic [63:0] in_data;
  logic [7:0]  in_valid, in_ready;
  logic        mode, out_ready, out_valid;
  logic [2:0]  sel, out_ch;
  logic [7:0]  out_data;

  // Six-channel instance for the out-of-range select case
  logic        b_rst;
  logic [47:0] b_in_data;
  logic [5:0]  b_in_valid, b_in_ready;
  logic        b_mode, b_out_ready, b_out_valid;
  logic [2:0]  b_sel, b_out_ch;
  logic [7:0]  b_out_data;

  int n_cmp = 0;
  int n_err = 0;

  mux_stream_rr #(.NCH(8), .W(8)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_stream_rr #(.NCH(6), .W(8)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp[4];
    rr_exp = '{2, 7, 2, 7};

    rst = 1'b1; in_valid = 8'hFF; mode = 1'b0; sel = 3'd0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
    b_rst = 1'b1; b_in_valid = '0; b_mode = 1'b0; b_sel = 3'd0; b_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) b_in_data[i*8 +: 8] = 8'h60 + 8'(i);

    // Reset with every channel requesting
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_ch", 32'(out_ch), 32'h0);

    rst = 1'b0; in_valid = 8'h00;
    tick();
    chk("idle_out_valid", 32'(out_valid), 32'h0);
    tick();
    chk("idle_out_valid2", 32'(out_valid), 32'h0);

    // Fixed select on channel 3
    mode = 1'b0; sel = 3'd3; in_data[3*8 +: 8] = 8'hA5; in_valid = 8'hFF;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'h08);
    tick();
    chk("fix_out_data", 32'(out_data), 32'hA5);
    chk("fix_out_ch", 32'(out_ch), 32'h3);
    chk("fix_out_valid", 32'(out_valid), 32'h1);

    // Round-robin from a freshly reset pointer
    rst = 1'b1; in_valid = 8'h00;
    tick();
    rst = 1'b0; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("rr_ch%0d", c), 32'(out_ch), 32'(c % 8));
      chk($sformatf("rr_v%0d", c), 32'(out_valid), 32'h1);
    end
    // Pointer now sits at 2; only channels 2 and 7 request
    in_valid = 8'b1000_0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("sparse_ch%0d", c), 32'(out_ch), 32'(rr_exp[c]));
    end

    // Backpressure: hold 3C while the producer keeps changing data
    mode = 1'b0; sel = 3'd5; in_data[5*8 +: 8] = 8'h3C; in_valid = 8'h20; out_ready = 1'b1;
    tick();
    chk("bp_load_data", 32'(out_data), 32'h3C);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_data[5*8 +: 8] = 8'h40 + 8'(c);
      #1;
      chk($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'h00);
      tick();
      chk($sformatf("bp_data%0d", c), 32'(out_data), 32'h3C);
      chk($sformatf("bp_valid%0d", c), 32'(out_valid), 32'h1);
    end
    in_data[5*8 +: 8] = 8'h77; out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h20);
    tick();
    chk("bp_release_data", 32'(out_data), 32'h77);
    chk("bp_release_valid", 32'(out_valid), 32'h1);

    // Move the pointer off zero, stall, then reset mid-word
    mode = 1'b1; in_valid = 8'h04;
    tick();
    chk("pre_rst_ch", 32'(out_ch), 32'h2);
    out_ready = 1'b0; in_valid = 8'h81;
    tick();
    chk("stall_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'h00);
    tick();
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_data", 32'(out_data), 32'h00);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h01);
    tick();
    chk("post_rst_ch0", 32'(out_ch), 32'h0);
    tick();
    chk("post_rst_ch1", 32'(out_ch), 32'h7);

    // Six-channel instance: last legal select, then out-of-range select
    b_rst = 1'b0; b_mode = 1'b0; b_sel = 3'd5; b_in_valid = 6'h3F; b_out_ready = 1'b1;
    #1;
    chk("b_sel5_ready", 32'(b_in_ready), 32'h20);
    tick();
    chk("b_sel5_data", 32'(b_out_data), 32'h65);
    chk("b_sel5_ch", 32'(b_out_ch), 32'h5);
    b_sel = 3'd7;
    #1;
    chk("b_sel7_ready", 32'(b_in_ready), 32'h00);
    tick();
    chk("b_sel7_valid", 32'(b_out_valid), 32'h0);
    chk("b_sel7_ch_hold", 32'(b_out_ch), 32'h5);
    b_mode = 1'b1;
    tick();
    chk("b_rr_ch", 32'(b_out_ch), 32'h0);
    tick();
    chk("b_rr_ch_next", 32'(b_out_ch), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
